friet_stream_buffer_out: RTL and testbench

//  Wide-to-narrow stream serializer: the transmit-side counterpart of the narrow-to-wide input buffer.
//  - Accepts one DIN_WIDTH block with byte count and last flag.
//  - Emits it as DOUT_WIDTH words, lowest bytes first, each with its own byte count.
//  - Sits between the FRIET core output (ciphertext/tag blocks) and the narrow external output bus.

---
 rtl/friet_stream_buffer_out.sv | 131 +++++++++++++
 tb/tb_friet_stream_buffer_out.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/friet_stream_buffer_out.sv
// -----------------------------------------------------------------------------
// friet_stream_buffer_out
//
// Wide-to-narrow stream serializer. Holds one DIN_WIDTH block taken from the
// FRIET core output and emits it on the narrow output bus as DOUT_WIDTH words,
// lowest bytes first. Every word carries its own byte count, and the final
// word of a last block is flagged with dout_last.
//
// Ports
//   clk, rst           clock (rising edge) and synchronous active-high reset
//   din                wide block, byte 0 in bits [7:0]
//   din_size           valid bytes in din (values above the block size clamp)
//   din_last           block is the last of the message
//   din_valid/ready    input handshake
//   dout               narrow word, low DOUT_WIDTH bits of the held block
//   dout_size          valid bytes in dout, min(remaining, DOUT_WIDTH/8)
//   dout_valid/ready   output handshake
//   dout_last          word is the final word of the final block
//   reg_buffer_empty   no block currently held
//
// Configuration macro
//   FRIET_STREAM_BUFFER_OUT_ZERO_PAD_EN
//     defined   : dout bytes at index >= dout_size are driven to zero
//     undefined : dout is the raw low word of the buffer (stale bytes visible)
// -----------------------------------------------------------------------------
module friet_stream_buffer_out #(
  parameter int DIN_WIDTH       = 128,
  parameter int DIN_SIZE_WIDTH  = 4,
  parameter int DOUT_WIDTH      = 32,
  parameter int DOUT_SIZE_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIN_WIDTH-1:0]       din,
  input  logic [DIN_SIZE_WIDTH:0]    din_size,
  input  logic                       din_last,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic [DOUT_WIDTH-1:0]      dout,
  output logic [DOUT_SIZE_WIDTH:0]   dout_size,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       dout_last,
  output logic                       reg_buffer_empty
);

  localparam int WORD_BYTES  = DOUT_WIDTH / 8;
  localparam int BLOCK_BYTES = DIN_WIDTH / 8;
  localparam logic [DIN_SIZE_WIDTH:0]  WORD_BYTES_W  = (DIN_SIZE_WIDTH+1)'(WORD_BYTES);
  localparam logic [DIN_SIZE_WIDTH:0]  BLOCK_BYTES_W = (DIN_SIZE_WIDTH+1)'(BLOCK_BYTES);
  localparam logic [DOUT_SIZE_WIDTH:0] WORD_BYTES_O  = (DOUT_SIZE_WIDTH+1)'(WORD_BYTES);

  logic [DIN_WIDTH-1:0]      reg_buffer_q, reg_buffer_d;
  logic [DIN_SIZE_WIDTH:0]   reg_remaining_q, reg_remaining_d;
  logic                      reg_last_q, reg_last_d;
  logic                      reg_full_q, reg_full_d;

  logic                      last_word;
  logic                      dout_hs;
  logic                      din_hs;
  logic                      din_drop;
  logic [DIN_SIZE_WIDTH:0]   din_size_clamped;

  // The word currently on dout is the final one of the held block.
  assign last_word = (reg_remaining_q <= WORD_BYTES_W);
  assign dout_hs   = reg_full_q & dout_ready;

  // A new block may load in the same cycle the final word leaves, so
  // consecutive blocks stream without a bubble.
  assign din_ready = ~rst & (~reg_full_q | (dout_hs & last_word));
  assign din_hs    = din_valid & din_ready;

  assign din_size_clamped = (din_size > BLOCK_BYTES_W) ? BLOCK_BYTES_W : din_size;
  // An empty non-last block carries nothing: accept it but never hold it.
  assign din_drop         = (din_size_clamped == '0) & ~din_last;

  always_comb begin
    reg_buffer_d    = reg_buffer_q;
    reg_remaining_d = reg_remaining_q;
    reg_last_d      = reg_last_q;
    reg_full_d      = reg_full_q;

    if (dout_hs) begin
      if (last_word) begin
        reg_full_d = 1'b0;
      end else begin
        reg_buffer_d    = reg_buffer_q >> DOUT_WIDTH;
        reg_remaining_d = reg_remaining_q - WORD_BYTES_W;
      end
    end

    if (din_hs && !din_drop) begin
      reg_buffer_d    = din;
      reg_remaining_d = din_size_clamped;
      reg_last_d      = din_last;
      reg_full_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_full_q      <= 1'b0;
      reg_remaining_q <= '0;
      reg_last_q      <= 1'b0;
    end else begin
      reg_full_q      <= reg_full_d;
      reg_remaining_q <= reg_remaining_d;
      reg_last_q      <= reg_last_d;
    end
  end

  // Data path carries no reset; its content is meaningless while empty.
  always_ff @(posedge clk) begin
    reg_buffer_q <= reg_buffer_d;
  end

  assign dout_valid       = reg_full_q;
  assign dout_last        = reg_full_q & reg_last_q & last_word;
  assign reg_buffer_empty = ~reg_full_q;
  // remaining never exceeds WORD_BYTES on the last word, so the low bits suffice.
  assign dout_size        = last_word ? reg_remaining_q[DOUT_SIZE_WIDTH:0] : WORD_BYTES_O;

`ifdef FRIET_STREAM_BUFFER_OUT_ZERO_PAD_EN
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_pad
    assign dout[8*gi +: 8] = ((DOUT_SIZE_WIDTH+1)'(gi) < dout_size) ? reg_buffer_q[8*gi +: 8] : 8'h00;
  end
`else
  assign dout = reg_buffer_q[DOUT_WIDTH-1:0];
`endif

endmodule

// File: tb/tb_friet_stream_buffer_out.sv
// -----------------------------------------------------------------------------
// tb_friet_stream_buffer_out
//
// Drives directed and random blocks into friet_stream_buffer_out. A queue of
// expected output words, built from each accepted block, is compared with the
// DUT every cycle; directed sections also check hand-computed literal words.
// -----------------------------------------------------------------------------
module tb_friet_stream_buffer_out;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic [4:0]   din_size;
  logic         din_last;
  logic         din_valid;
  logic         din_ready;
  logic [31:0]  dout;
  logic [2:0]   dout_size;
  logic         dout_valid;
  logic         dout_ready;
  logic         dout_last;
  logic         reg_buffer_empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  size;
    logic        last;
  } word_t;

  word_t exp_q[$];

  friet_stream_buffer_out dut (
    .clk              (clk),
    .rst              (rst),
    .din              (din),
    .din_size         (din_size),
    .din_last         (din_last),
    .din_valid        (din_valid),
    .din_ready        (din_ready),
    .dout             (dout),
    .dout_size        (dout_size),
    .dout_valid       (dout_valid),
    .dout_ready       (dout_ready),
    .dout_last        (dout_last),
    .reg_buffer_empty (reg_buffer_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected word stream for one accepted block, from the byte-level rules.
  task automatic push_block(input logic [127:0] d, input int sz_in, input logic lst);
    int sz, n, rem;
    word_t w;
    sz = (sz_in > 16) ? 16 : sz_in;
    if (sz == 0 && !lst) return;
    n = (sz == 0) ? 1 : (sz + 3) / 4;
    for (int k = 0; k < n; k++) begin
      rem    = sz - 4 * k;
      w.data = d[32*k +: 32];
      w.size = 3'((rem > 4) ? 4 : rem);
      w.last = lst && (k == n - 1);
`ifdef FRIET_STREAM_BUFFER_OUT_ZERO_PAD_EN
      for (int b = 0; b < 4; b++)
        if (b >= int'(w.size)) w.data[8*b +: 8] = 8'h00;
`endif
      exp_q.push_back(w);
    end
  endtask

  // Every-cycle compare against the expected word queue.
  logic         cap_rst, cap_dhs, cap_ihs, cap_last;
  logic [127:0] cap_din;
  logic [4:0]   cap_size;
  initial begin
    logic exp_valid, exp_ready;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_valid = (exp_q.size() != 0);
      exp_ready = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && dout_ready));
      chk("dout_valid", 64'(dout_valid), 64'(exp_valid));
      chk("din_ready", 64'(din_ready), 64'(exp_ready));
      chk("reg_buffer_empty", 64'(reg_buffer_empty), 64'(!exp_valid));
      if (exp_valid && dout_valid) begin
        chk("dout", 64'(dout), 64'(exp_q[0].data));
        chk("dout_size", 64'(dout_size), 64'(exp_q[0].size));
        chk("dout_last", 64'(dout_last), 64'(exp_q[0].last));
      end
      cap_rst  = rst;
      cap_dhs  = exp_valid && dout_ready;
      cap_ihs  = din_valid && exp_ready;
      cap_din  = din;
      cap_size = din_size;
      cap_last = din_last;
      @(posedge clk);
      if (cap_rst) exp_q.delete();
      else begin
        if (cap_dhs) void'(exp_q.pop_front());
        if (cap_ihs) push_block(cap_din, int'(cap_size), cap_last);
      end
    end
  end

  task automatic send_block(input logic [127:0] d, input int sz, input logic lst, output int cycles);
    logic acc, done;
    din = d; din_size = sz[4:0]; din_last = lst; din_valid = 1'b1;
    cycles = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) done = 1'b1;
    end
    if (done) $display("block accepted: size %0d last %0d after %0d cycles", sz, lst, cycles);
    else begin
      checks++; errors++;
      $display("FAIL send_block: din_ready never seen, got timeout expected accept");
      cycles = -1;
    end
  endtask

  // Requires dout_ready=1; checks one word and lets it handshake.
  task automatic expect_word(input string name, input logic [31:0] d, input int sz, input logic lst);
    @(negedge clk);
    chk(name, {dout_valid, dout, dout_size, dout_last}, {1'b1, d, 3'(sz), lst});
    @(posedge clk); #1;
  endtask

  task automatic wait_empty();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (reg_buffer_empty) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL drain: got buffer still full expected empty within 200 cycles");
    end
  endtask

  initial begin
    logic [127:0] pat, pat2;
    logic [31:0]  w1_exp;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      pat[8*i +: 8]  = 8'(i);
      pat2[8*i +: 8] = 8'(i + 16);
    end

    rst = 1'b1; din = '0; din_size = '0; din_last = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset dout_valid", 64'(dout_valid), 64'd0);
    chk("reset din_ready", 64'(din_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; dout_ready = 1'b1;
    @(negedge clk);
    chk("post-reset din_ready", 64'(din_ready), 64'd1);
    @(posedge clk); #1;

    // 16-byte last block
    send_block(pat, 16, 1'b1, cyc);
    din_valid = 1'b0;
    expect_word("t1 w0", 32'h03020100, 4, 1'b0);
    expect_word("t1 w1", 32'h07060504, 4, 1'b0);
    expect_word("t1 w2", 32'h0B0A0908, 4, 1'b0);
    expect_word("t1 w3", 32'h0F0E0D0C, 4, 1'b1);

    // 6-byte last block
`ifdef FRIET_STREAM_BUFFER_OUT_ZERO_PAD_EN
    w1_exp = 32'h00000504;
`else
    w1_exp = 32'h07060504;
`endif
    send_block(pat, 6, 1'b1, cyc);
    din_valid = 1'b0;
    expect_word("t2 w0", 32'h03020100, 4, 1'b0);
    expect_word("t2 w1", w1_exp, 2, 1'b1);

    // empty-message marker, then dropped empty non-last block
    send_block('0, 0, 1'b1, cyc);
    din_valid = 1'b0;
    expect_word("t3 marker", 32'h0, 0, 1'b1);
    send_block(pat, 0, 1'b0, cyc);
    din_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3 drop valid/ready", {dout_valid, din_ready}, {1'b0, 1'b1});
      @(posedge clk); #1;
    end

    // back-to-back blocks: second accepted on the 4th word cycle
    send_block(pat, 16, 1'b0, cyc);
    send_block(pat2, 16, 1'b1, cyc);
    chk("t4 second block wait", 64'(cyc), 64'd4);
    din_valid = 1'b0;
    expect_word("t4 b1 w0", 32'h13121110, 4, 1'b0);
    wait_empty();

    // reset in the middle of a block
    send_block(pat, 16, 1'b1, cyc);
    din_valid = 1'b0;
    expect_word("t6 w0", 32'h03020100, 4, 1'b0);
    expect_word("t6 w1", 32'h07060504, 4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6 rst valid/ready", {dout_valid, din_ready}, {1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6 after rst valid/ready", {dout_valid, din_ready}, {1'b0, 1'b1});
    @(posedge clk); #1;
    send_block(pat2, 16, 1'b1, cyc);
    din_valid = 1'b0;
    expect_word("t6 new w0", 32'h13121110, 4, 1'b0);
    expect_word("t6 new w1", 32'h17161514, 4, 1'b0);
    expect_word("t6 new w2", 32'h1B1A1918, 4, 1'b0);
    expect_word("t6 new w3", 32'h1F1E1D1C, 4, 1'b1);

    // random traffic with stalls, illegal sizes and rare resets
    for (int i = 0; i < 4000; i++) begin
      din        = {$urandom(), $urandom(), $urandom(), $urandom()};
      din_size   = 5'($urandom_range(0, 20));
      din_last   = 1'($urandom_range(0, 1));
      din_valid  = ($urandom_range(0, 2) != 0);
      dout_ready = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 399) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    wait_empty();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
